// File: rtl/jtframe_sdram_pkg.sv
// Shared constants for the single-bank SDRAM request path: command widths,
// idle byte mask, watchdog counter width and the arbiter debug state encoding.
package jtframe_sdram_pkg;

    localparam int DW     = 16;
    localparam int MW     = 2;
    localparam int TOUT_W = 8;

    localparam logic [MW-1:0] MASK_IDLE = 2'b11;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'd0,
        ARB_ISSUE = 2'd1,
        ARB_WAIT  = 2'd2
    } arb_state_e;

    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/jtframe_arb_pick.sv
// Combinational slot picker: lowest active index (RR=0) or first active index
// after ptr, wrapping modulo SW (RR=1).
module jtframe_arb_pick
    import jtframe_sdram_pkg::*;
#(
    parameter int SW = 6,
    parameter int RR = 0,
    parameter int PW = idx_width(SW)
) (
    input  logic [SW-1:0] active,
    input  logic [PW-1:0] ptr,
    output logic [SW-1:0] win,
    output logic [PW-1:0] win_idx
);

    int   idx;
    logic found;

    always_comb begin
        win     = '0;
        win_idx = '0;
        found   = 1'b0;
        idx     = 0;
        for (int k = 0; k < SW; k++) begin
            idx = (RR != 0) ? int'(ptr) + 1 + k : k;
            if (idx >= SW) idx = idx - SW;
            if (idx >= SW) idx = idx - SW;
            if (!found && active[idx]) begin
                found    = 1'b1;
                win      = '0;
                win[idx] = 1'b1;
                win_idx  = PW'(idx);
            end
        end
    end

endmodule

// File: rtl/jtframe_ram_nslot_arb.sv
// N-slot SDRAM arbiter: one grant per transaction, fixed priority or round-robin.
// Optional watchdog enabled with the JTFRAME_ARB_TIMEOUT_EN macro.
module jtframe_ram_nslot_arb
    import jtframe_sdram_pkg::*;
#(
    parameter int SDRAMW  = 22,
    parameter int SW      = 6,
    parameter int WRSLOTS = 2,
    parameter int RR      = 0,
    parameter int TOUT    = 255,
    parameter int WN      = (WRSLOTS > 0) ? WRSLOTS : 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SW-1:0]        req,
    input  logic [SW-1:0]        req_rnw,
    input  logic [SW*SDRAMW-1:0] slot_addr,
    input  logic [WN*DW-1:0]     slot_din,
    input  logic [WN*MW-1:0]     slot_wrmask,
    output logic [SW-1:0]        slot_sel,
    input  logic                 sdram_ack,
    output logic                 sdram_rd,
    output logic                 sdram_wr,
    output logic [SDRAMW-1:0]    sdram_addr,
    input  logic                 data_rdy,
    output logic [DW-1:0]        data_write,
    output logic [MW-1:0]        sdram_wrmask,
    output logic                 timeout_err,
    output arb_state_e           dbg_state
);

    localparam int PW = idx_width(SW);

    // Handshake: sdram_rd/sdram_wr are the request valid and stay high until
    // sdram_ack (ready) is seen; data_rdy then closes the transaction.
    logic [SW-1:0]     slot_sel_q, slot_sel_d;
    logic              rd_q, rd_d, wr_q, wr_d;
    logic [SDRAMW-1:0] addr_q, addr_d;
    logic [DW-1:0]     dw_q, dw_d;
    logic [MW-1:0]     mask_q, mask_d;
    logic [PW-1:0]     ptr_q, ptr_d;

    logic [SW-1:0] active, win;
    logic [PW-1:0] win_idx;
    logic          arb_en, granted, is_write;
    int            wsel;

    assign active  = req & ~slot_sel_q;
    assign arb_en  = (slot_sel_q == '0) || data_rdy;
    assign granted = arb_en && (active != '0);

    jtframe_arb_pick #(.SW(SW), .RR(RR), .PW(PW)) u_pick (
        .active  (active),
        .ptr     (ptr_q),
        .win     (win),
        .win_idx (win_idx)
    );

    assign is_write = (int'(win_idx) < WRSLOTS) && !req_rnw[win_idx];
    assign wsel     = is_write ? int'(win_idx) : 0;

`ifdef JTFRAME_ARB_TIMEOUT_EN
    logic [TOUT_W-1:0] cnt_q, cnt_d;
    logic              err_q, err_d;
    logic              expire;

    // data_rdy in the expiry cycle wins: expire requires data_rdy low.
    assign expire = (slot_sel_q != '0) && !data_rdy && (cnt_q == TOUT_W'(TOUT - 1));
`endif

    always_comb begin
        slot_sel_d = slot_sel_q;
        rd_d       = rd_q;
        wr_d       = wr_q;
        addr_d     = addr_q;
        dw_d       = dw_q;
        mask_d     = mask_q;
        ptr_d      = ptr_q;
        if (arb_en) begin
            slot_sel_d = win;
            if (granted) begin
                ptr_d  = win_idx;
                addr_d = slot_addr[int'(win_idx)*SDRAMW +: SDRAMW];
                if (is_write) begin
                    wr_d   = 1'b1;
                    rd_d   = 1'b0;
                    dw_d   = slot_din[wsel*DW +: DW];
                    mask_d = slot_wrmask[wsel*MW +: MW];
                end else begin
                    rd_d   = 1'b1;
                    wr_d   = 1'b0;
                    mask_d = MASK_IDLE;
                end
            end else begin
                rd_d = 1'b0;
                wr_d = 1'b0;
            end
        end else if (sdram_ack) begin
            rd_d = 1'b0;
            wr_d = 1'b0;
        end
`ifdef JTFRAME_ARB_TIMEOUT_EN
        err_d = 1'b0;
        cnt_d = cnt_q;
        if (granted) begin
            cnt_d = '0;
        end else if ((slot_sel_q != '0) && !data_rdy) begin
            cnt_d = cnt_q + TOUT_W'(1);
        end
        if (expire) begin
            slot_sel_d = '0;
            rd_d       = 1'b0;
            wr_d       = 1'b0;
            err_d      = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_sel_q <= '0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            addr_q     <= '0;
            dw_q       <= '0;
            mask_q     <= MASK_IDLE;
            ptr_q      <= PW'(SW - 1);
        end else begin
            slot_sel_q <= slot_sel_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            addr_q     <= addr_d;
            dw_q       <= dw_d;
            mask_q     <= mask_d;
            ptr_q      <= ptr_d;
        end
    end

`ifdef JTFRAME_ARB_TIMEOUT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end
    assign timeout_err = err_q;
`else
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        if (slot_sel_q == '0)   dbg_state = ARB_IDLE;
        else if (rd_q || wr_q)  dbg_state = ARB_ISSUE;
        else                    dbg_state = ARB_WAIT;
    end

    assign slot_sel     = slot_sel_q;
    assign sdram_rd     = rd_q;
    assign sdram_wr     = wr_q;
    assign sdram_addr   = addr_q;
    assign data_write   = dw_q;
    assign sdram_wrmask = mask_q;

endmodule

// File: tb/tb_jtframe_ram_nslot_arb.sv
// Bench for jtframe_ram_nslot_arb: a fixed-priority SW=6 and a round-robin SW=4
// instance share stimulus; a transaction-level model checks both every cycle.
module tb_jtframe_ram_nslot_arb;
    import jtframe_sdram_pkg::*;

    localparam int AW = 22;
    localparam int TO = 16;
`ifdef JTFRAME_ARB_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            rst;
    logic [5:0]      req, rnw;
    logic [6*AW-1:0] saddr;
    logic [31:0]     sdin;
    logic [3:0]      smask;
    logic            ack, rdy;

    logic [5:0]    f_sel;
    logic          f_rd, f_wr, f_err;
    logic [AW-1:0] f_addr;
    logic [15:0]   f_dw;
    logic [1:0]    f_mask;
    arb_state_e    f_dbg;

    logic [3:0]    r_sel;
    logic          r_rd, r_wr, r_err;
    logic [AW-1:0] r_addr;
    logic [15:0]   r_dw;
    logic [1:0]    r_mask;
    arb_state_e    r_dbg;

    jtframe_ram_nslot_arb #(.SDRAMW(AW), .SW(6), .WRSLOTS(2), .RR(0), .TOUT(TO)) dut_fp (
        .clk(clk), .rst(rst), .req(req), .req_rnw(rnw), .slot_addr(saddr),
        .slot_din(sdin), .slot_wrmask(smask), .slot_sel(f_sel), .sdram_ack(ack),
        .sdram_rd(f_rd), .sdram_wr(f_wr), .sdram_addr(f_addr), .data_rdy(rdy),
        .data_write(f_dw), .sdram_wrmask(f_mask), .timeout_err(f_err), .dbg_state(f_dbg)
    );

    jtframe_ram_nslot_arb #(.SDRAMW(AW), .SW(4), .WRSLOTS(2), .RR(1), .TOUT(TO)) dut_rr (
        .clk(clk), .rst(rst), .req(req[3:0]), .req_rnw(rnw[3:0]), .slot_addr(saddr[4*AW-1:0]),
        .slot_din(sdin), .slot_wrmask(smask), .slot_sel(r_sel), .sdram_ack(ack),
        .sdram_rd(r_rd), .sdram_wr(r_wr), .sdram_addr(r_addr), .data_rdy(rdy),
        .data_write(r_dw), .sdram_wrmask(r_mask), .timeout_err(r_err), .dbg_state(r_dbg)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [AW-1:0] a_of(input int i);
        return saddr[i*AW +: AW];
    endfunction

    // Reference model: one record per DUT (0 = fixed priority, 1 = round-robin)
    int            m_owner[2], m_ptr[2], m_cnt[2];
    logic          m_rd[2], m_wr[2], m_err[2];
    logic [AW-1:0] m_addr[2];
    logic [15:0]   m_dw[2];
    logic [1:0]    m_mask[2];

    task automatic model_next(input int d);
        int nsl;
        int win;
        nsl = (d == 1) ? 4 : 6;
        win = -1;
        if (rst) begin
            m_owner[d] = -1; m_ptr[d] = nsl - 1; m_cnt[d] = 0;
            m_rd[d] = 0; m_wr[d] = 0; m_err[d] = 0;
            m_addr[d] = '0; m_dw[d] = '0; m_mask[d] = 2'b11;
            return;
        end
        m_err[d] = 0;
        if (m_owner[d] < 0 || rdy) begin
            for (int k = 1; k <= nsl; k++) begin
                int i;
                i = (d == 1) ? (m_ptr[d] + k) % nsl : k - 1;
                if (win < 0 && req[i] && i != m_owner[d]) win = i;
            end
            if (win >= 0) begin
                m_owner[d] = win; m_ptr[d] = win; m_cnt[d] = 0;
                m_addr[d] = a_of(win);
                if (win < 2 && !rnw[win]) begin
                    m_wr[d] = 1; m_rd[d] = 0;
                    m_dw[d] = sdin[win*16 +: 16];
                    m_mask[d] = smask[win*2 +: 2];
                end else begin
                    m_rd[d] = 1; m_wr[d] = 0; m_mask[d] = 2'b11;
                end
            end else begin
                m_owner[d] = -1; m_rd[d] = 0; m_wr[d] = 0;
            end
        end else begin
            if (ack) begin m_rd[d] = 0; m_wr[d] = 0; end
            m_cnt[d]++;
            if (TO_EN && m_cnt[d] == TO) begin
                m_owner[d] = -1; m_rd[d] = 0; m_wr[d] = 0; m_err[d] = 1;
            end
        end
    endtask

    task automatic model_check(input int d);
        logic [5:0]  esel, gsel;
        logic [63:0] got, exp;
        esel = (m_owner[d] >= 0) ? 6'(1 << m_owner[d]) : 6'd0;
        if (d == 0) begin
            gsel = f_sel;
            got = {13'd0, gsel, f_rd, f_wr, f_addr, f_dw, f_mask, f_err};
        end else begin
            gsel = {2'b00, r_sel};
            got = {13'd0, gsel, r_rd, r_wr, r_addr, r_dw, r_mask, r_err};
        end
        exp = {13'd0, esel, m_rd[d], m_wr[d], m_addr[d], m_dw[d], m_mask[d], m_err[d]};
        check((d == 0) ? "model_fp" : "model_rr", got, exp);
    endtask

    task automatic step();
        model_next(0);
        model_next(1);
        @(posedge clk);
        #1;
        model_check(0);
        model_check(1);
    endtask

    function automatic int sel_idx(input logic [3:0] s);
        int r;
        r = -1;
        for (int i = 0; i < 4; i++) if (s[i]) r = i;
        return r;
    endfunction

    typedef struct {
        logic [5:0]    req, rnw;
        logic          ack, rdy;
        logic [5:0]    sel;
        logic          rd, wr;
        logic [1:0]    mask;
        logic [AW-1:0] addr;
        logic [15:0]   dw;
    } vec_t;

    vec_t tbl[13];

    function automatic vec_t mkv(input logic [5:0] rq, input logic [5:0] rn, input logic a,
                                 input logic dr, input logic [5:0] s, input logic erd,
                                 input logic ewr, input logic [1:0] em, input int aslot,
                                 input logic [15:0] edw);
        vec_t v;
        v.req = rq; v.rnw = rn; v.ack = a; v.rdy = dr;
        v.sel = s; v.rd = erd; v.wr = ewr; v.mask = em; v.addr = a_of(aslot); v.dw = edw;
        return v;
    endfunction

    int first_k, pulses, prev, gidx;

    initial begin
        rst = 1'b1; req = '0; rnw = '1; ack = 0; rdy = 0;
        sdin = {16'hA55A, 16'h1234}; smask = {2'b10, 2'b01};
        for (int i = 0; i < 6; i++) saddr[i*AW +: AW] = AW'(22'h3A000 + i * 22'h111);
        step();
        step();
        check("reset_fp", {f_sel, f_rd, f_wr, f_addr, f_dw, f_mask, f_err},
              {6'd0, 1'b0, 1'b0, 22'd0, 16'd0, 2'b11, 1'b0});
        check("reset_rr", {r_sel, r_rd, r_wr, r_addr, r_dw, r_mask, r_err},
              {4'd0, 1'b0, 1'b0, 22'd0, 16'd0, 2'b11, 1'b0});
        rst = 1'b0;

        tbl[0]  = mkv(6'b100100, 6'h3F, 0, 0, 6'b000100, 1, 0, 2'b11, 2, 16'h0);
        tbl[1]  = mkv(6'b100100, 6'h3F, 1, 0, 6'b000100, 0, 0, 2'b11, 2, 16'h0);
        tbl[2]  = mkv(6'b100100, 6'h3F, 0, 0, 6'b000100, 0, 0, 2'b11, 2, 16'h0);
        tbl[3]  = mkv(6'b100100, 6'h3F, 0, 1, 6'b100000, 1, 0, 2'b11, 5, 16'h0);
        tbl[4]  = mkv(6'b000000, 6'h3F, 1, 0, 6'b100000, 0, 0, 2'b11, 5, 16'h0);
        tbl[5]  = mkv(6'b000000, 6'h3F, 0, 1, 6'b000000, 0, 0, 2'b11, 5, 16'h0);
        tbl[6]  = mkv(6'b000010, 6'h3D, 0, 0, 6'b000010, 0, 1, 2'b10, 1, 16'hA55A);
        tbl[7]  = mkv(6'b000010, 6'h3D, 1, 0, 6'b000010, 0, 0, 2'b10, 1, 16'hA55A);
        tbl[8]  = mkv(6'b000000, 6'h3F, 0, 1, 6'b000000, 0, 0, 2'b10, 1, 16'hA55A);
        tbl[9]  = mkv(6'b001000, 6'h37, 0, 0, 6'b001000, 1, 0, 2'b11, 3, 16'hA55A);
        tbl[10] = mkv(6'b001100, 6'h37, 1, 1, 6'b000100, 1, 0, 2'b11, 2, 16'hA55A);
        tbl[11] = mkv(6'b000000, 6'h3F, 1, 0, 6'b000100, 0, 0, 2'b11, 2, 16'hA55A);
        tbl[12] = mkv(6'b000000, 6'h3F, 0, 1, 6'b000000, 0, 0, 2'b11, 2, 16'hA55A);

        for (int r = 0; r < 13; r++) begin
            req = tbl[r].req; rnw = tbl[r].rnw; ack = tbl[r].ack; rdy = tbl[r].rdy;
            step();
            check($sformatf("vec%0d", r), {f_sel, f_rd, f_wr, f_mask, f_addr, f_dw},
                  {tbl[r].sel, tbl[r].rd, tbl[r].wr, tbl[r].mask, tbl[r].addr, tbl[r].dw});
        end
        req = '0; ack = 0; rdy = 0; rnw = '1;

        // Reset while waiting for data, then a stale data_rdy after release
        req = 6'b000001; step();
        req = '0; ack = 1; step();
        ack = 0; step();
        rst = 1; step();
        rst = 0; step();
        rdy = 1; step();
        rdy = 0;
        check("rst_wait", {f_sel, f_rd, f_wr, f_addr, f_dw, f_mask, f_err},
              {6'd0, 1'b0, 1'b0, 22'd0, 16'd0, 2'b11, 1'b0});
        check("rst_dbg", 64'(f_dbg), 64'(ARB_IDLE));

        // Round-robin order with all four slots requesting
        req = 6'b001111; step();
        prev = -1;
        for (int g = 0; g < 5; g++) begin
            gidx = sel_idx(r_sel);
            check($sformatf("rr_grant%0d", g), 64'(gidx), 64'(g % 4));
            if (prev >= 0) check($sformatf("rr_nodup%0d", g), 64'(gidx == prev), 64'(0));
            prev = gidx;
            if (g < 4) begin
                ack = 1; step();
                ack = 0; step();
                step();
                rdy = 1; step();
                rdy = 0;
            end
        end
        req = '0; rdy = 1; step();
        rdy = 0; step();

`ifdef JTFRAME_ARB_TIMEOUT_EN
        req = 6'b000001; step();
        req = '0;
        first_k = -1; pulses = 0;
        for (int k = 1; k <= 40; k++) begin
            ack = (k == 1);
            step();
            if (f_err) begin
                pulses++;
                if (first_k < 0) first_k = k;
                check("tout_sel", 64'(f_sel), 64'(0));
            end
        end
        ack = 0;
        check("tout_cycle", 64'(first_k), 64'(TO));
        check("tout_pulses", 64'(pulses), 64'(1));
`endif

        for (int c = 0; c < 800; c++) begin
            rst = ($urandom_range(0, 99) == 0);
            req = 6'($urandom);
            rnw = 6'($urandom);
            ack = ($urandom_range(0, 2) == 0);
            rdy = ($urandom_range(0, 3) == 0);
            sdin = $urandom;
            smask = 4'($urandom);
            for (int i = 0; i < 6; i++) saddr[i*AW +: AW] = AW'($urandom);
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
